// File: rtl/mc_mem_unit.sv
// mc_mem_unit: multicycle-CPU memory access unit.
// Turns the controller's mem_read/mem_write strobes into a single bus request.
// The request carries an alignment check and a bounded wait for mem_ack.
// Read data lands in ir or mdr, and stall holds the controller for the whole access.
module mc_mem_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        ir_write,
  input  logic        iord,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] b_reg,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value seen in the last permitted BUSY cycle (counter starts at 0).
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        irw_r;
  logic [31:0] sel_addr_s;
  logic        req_s;
  logic        aligned_s;
  logic        idle_s;
  logic        busy_s;

  // Address mux, request decode and state decode.
  always_comb begin
    sel_addr_s = pc;
    if (iord) begin
      sel_addr_s = alu_out;
    end else begin
      sel_addr_s = pc;
    end
    req_s     = mem_read | mem_write;
    aligned_s = (sel_addr_s[1:0] == 2'b00);
    idle_s    = (state_r == IDLE);
    busy_s    = (state_r == BUSY);
  end

  // Stall must rise in the request cycle itself, so it and align_err are combinational.
  always_comb begin
    stall     = 1'b0;
    align_err = 1'b0;
    if (rst) begin
      stall     = 1'b0;
      align_err = 1'b0;
    end else if (idle_s && req_s) begin
      stall     = aligned_s;
      align_err = ~aligned_s;
    end else begin
      stall     = busy_s;
      align_err = 1'b0;
    end
  end

  // Access FSM. The bus outputs are registered and hold their values for the whole BUSY period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      irw_r     <= 1'b0;
      ir        <= 32'd0;
      mdr       <= 32'd0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && aligned_s) begin
            state_r   <= BUSY;
            cnt_r     <= 8'd0;
            irw_r     <= ir_write;
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= {sel_addr_s[31:2], 2'b00};
            mem_wdata <= b_reg;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            // An ack arriving in the final counted cycle still completes normally.
            if (!mem_we) begin
              if (irw_r) begin
                ir <= mem_rdata;
              end else begin
                mdr <= mem_rdata;
              end
            end else begin
              ir <= ir;
            end
            state_r   <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            bus_err   <= 1'b1;
            state_r   <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          // One quiet cycle while the controller is still in its memory state.
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/mc_mem_unit.md
MC_MEM_UNIT -- requirements
Module: mc_mem_unit

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, max cycles of mem_req before abort (range 2..255).
REQ-002 SHALL provide clk  in  1  rising-edge clock.
REQ-003 SHALL provide rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL provide mem_read  in  1  controller read strobe (fetch or load).
REQ-005 SHALL provide mem_write  in  1  controller store strobe.
REQ-006 SHALL provide ir_write  in  1  route read data to ir; otherwise to mdr.
REQ-007 SHALL provide iord  in  1  address select: 0 = pc, 1 = alu_out.
REQ-008 SHALL provide pc, alu_out, b_reg  in  32 each  fetch address, data address, store data.
REQ-009 SHALL provide ir, mdr  out  32 each  instruction register, memory data register.
REQ-010 SHALL provide stall  out  1  high while the controller must hold its state.
REQ-011 SHALL provide align_err  out  1  one-cycle pulse on a misaligned request.
REQ-012 SHALL provide bus_err  out  1  sticky timeout flag.
REQ-013 SHALL provide mem_addr, mem_wdata  out  32 each; mem_req, mem_we  out  1 each; mem_rdata  in  32; mem_ack  in  1.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 IDLE: if (mem_read|mem_write) and the selected address has [1:0]==0, SHALL latch address, b_reg, write flag and ir_write, drive stall=1 combinationally in the same cycle, and enter BUSY.
REQ-016 IDLE with the selected address [1:0]!=0: SHALL drive align_err=1 for that cycle, issue no request, keep stall=0, and stay IDLE.
REQ-017 mem_read and mem_write both high: write SHALL win (mem_we=1), and no read data is captured.
REQ-018 BUSY: mem_req=1, stall=1; mem_addr, mem_wdata and mem_we SHALL hold the latched values, stable until exit.
REQ-019 BUSY with mem_ack=1 on a read: mem_rdata SHALL load into ir if the latched ir_write=1, else into mdr, on that edge; the FSM then enters DONE.
REQ-020 BUSY with mem_ack=1 on a write: SHALL enter DONE; ir and mdr stay unchanged.
REQ-021 SHALL count BUSY cycles with an 8-bit counter cleared on BUSY entry.
REQ-022 If the count reaches TIMEOUT without mem_ack, SHALL drop mem_req, set bus_err=1, leave ir and mdr unchanged, and enter DONE.
REQ-023 mem_ack in the same cycle the count reaches TIMEOUT: ack SHALL win; no bus_err.
REQ-024 DONE: stall=0, mem_req=0 for exactly one cycle; requests are ignored (controller still in its memory state); then IDLE.
REQ-025 mem_ack outside BUSY SHALL be ignored.
REQ-026 Latency: with ack in the Nth BUSY cycle, stall SHALL be high for N+1 cycles (request cycle plus N BUSY cycles).
REQ-027 mem_addr[1:0] SHALL always be 00; when not BUSY, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-028 bus_err SHALL stay set until rst.

Reset
REQ-029 rst SHALL immediately force IDLE, ir=0, mdr=0, counter=0, stall=0, mem_req=0, mem_we=0, align_err=0, bus_err=0.
REQ-030 rst mid-BUSY SHALL abort the access: mem_req drops at once and no data is captured.
REQ-031 After rst deasserts, the first edge SHALL sample requests normally.

Verification
REQ-032 Fetch: mem_read=1, ir_write=1, iord=0, pc=0x00000040; ack after 2 BUSY cycles with rdata=0x8C220004 -> mem_addr=0x40, stall high 3 cycles, ir=0x8C220004, mdr=0.
REQ-033 Store: mem_write=1, iord=1, alu_out=0x100, b_reg=0xDEADBEEF; ack after 1 cycle -> mem_we=1, mem_wdata=0xDEADBEEF, stall high 2 cycles, ir and mdr unchanged.
REQ-034 Timeout: TIMEOUT=4, no ack -> mem_req high 4 cycles, then bus_err=1 sticky, stall releases in DONE, mdr unchanged.
REQ-035 Misaligned: mem_read=1, iord=1, alu_out=0x102 -> align_err one-cycle pulse, mem_req never asserted, stall=0.
REQ-036 Reset mid-access: rst during BUSY cycle 2 -> mem_req=0 and stall=0 immediately, all outputs at reset values; a stray ack after reset is ignored.
REQ-037 Back-to-back: load immediately after a fetch, with DONE between them -> exactly two mem_req bursts, and DONE issues no duplicate request.
